if_fetch_queue: RTL

- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues one instruction-memory request at a time over a valid/ack handshake, and buffers returned instructions with their PC in a small FIFO.
- Presents the FIFO head to the decode stage with stall and flush support.
- Drives the PC register's load enable, so the PC advances only when a fetch is issued or a redirect occurs.

---
 rtl/if_fetch_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues one instruction-memory request at a time and
// buffers returned words with their PC in a small FIFO feeding decode.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    output logic        pc_ld_o,
    output logic        req_o,
    output logic [31:0] req_addr_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_pc4_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    logic [31:0]        inst_mem [DEPTH];
    logic [31:0]        pc_mem   [DEPTH];

    logic               issue;
    logic               push;
    logic               pop;

    assign issue   = (state_q == S_IDLE) && start_i && !flush_i && (count_q < FULL_CNT);
    assign push    = (state_q == S_WAIT) && mem_valid_i && !flush_i;
    assign valid_o = (count_q != '0);
    assign pop     = valid_o && !stall_i && !flush_i;
    assign pc_ld_o = issue | flush_i;

    assign req_o      = req_q;
    assign req_addr_o = req_addr_q;

    // req_addr_q doubles as the PC tag of the single outstanding request.
    always_comb begin
        state_d    = state_q;
        req_d      = issue;
        req_addr_d = issue ? pc_i : req_addr_q;
        case (state_q)
            S_IDLE: if (issue) state_d = S_WAIT;
            S_WAIT: begin
                if (mem_valid_i)  state_d = S_IDLE;
                else if (flush_i) state_d = S_DROP;
            end
            S_DROP: if (mem_valid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            req_addr_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= mem_data_i;
            pc_mem[wr_ptr_q]   <= req_addr_q;
        end
    end

    assign inst_o     = valid_o ? inst_mem[rd_ptr_q] : 32'd0;
    assign inst_pc_o  = valid_o ? pc_mem[rd_ptr_q] : 32'd0;
    assign inst_pc4_o = valid_o ? (pc_mem[rd_ptr_q] + 32'd4) : 32'd0;

endmodule
